// File: rtl/muldiv_unit.sv
// Purpose : iterative radix-2 32-bit multiply/divide unit producing MIPS HI/LO
//           (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Latency : start at edge N -> busy after edges N..N+32, done/HI/LO after edge N+33;
//           MTHI/MTLO visible the cycle after the sampling edge.
// Backpressure: start, hi_we and lo_we are dropped while busy; the controller stalls
//           MFHI/MFLO on busy.
// Ports   : clk, rst (sync, active-high); start/op/src_a/src_b launch an operation;
//           hi_we/lo_we/wdata write HI/LO; busy/done status; hi/lo architectural regs.
// Config  : define MULDIV_DIV_EN to build the divider; without it DIV/DIVU complete in
//           one cycle and leave HI/LO untouched.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand, or divisor
  logic [63:0] acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic        res_neg_q, res_neg_d;
  logic        dvd_neg_q, dvd_neg_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_signed;
  logic [31:0] abs_a, abs_b;
  logic [32:0] mul_sum;
  logic [63:0] prod;

  assign is_signed = ~op[0];
  assign abs_a     = src_a[31] ? (~src_a + 32'd1) : src_a;
  assign abs_b     = src_b[31] ? (~src_b + 32'd1) : src_b;
  assign mul_sum   = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  assign prod      = res_neg_q ? (~acc_q + 64'd1) : acc_q;

`ifdef MULDIV_DIV_EN
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [31:0] quo_fix, rem_fix;
  assign div_shift = {acc_q[63:32], acc_q[31]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign quo_fix   = res_neg_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
  assign rem_fix   = dvd_neg_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    res_neg_d = res_neg_q;
    dvd_neg_d = dvd_neg_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      S_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          op_d   = op;
          cnt_d  = 6'd0;
          busy_d = 1'b1;
          if (op[1]) begin
`ifdef MULDIV_DIV_EN
            if (src_b == 32'd0) begin
              // Raw dividend and no sign flags: the restoring loop then yields
              // quotient all-ones and remainder equal to src_a untouched.
              opnd_d    = 32'd0;
              acc_d     = {32'd0, src_a};
              res_neg_d = 1'b0;
              dvd_neg_d = 1'b0;
            end else begin
              opnd_d    = is_signed ? abs_b : src_b;
              acc_d     = {32'd0, (is_signed ? abs_a : src_a)};
              res_neg_d = is_signed & (src_a[31] ^ src_b[31]);
              dvd_neg_d = is_signed & src_a[31];
            end
            state_d = S_CALC;
`else
            state_d = S_FIX;
`endif
          end else begin
            opnd_d    = is_signed ? abs_a : src_a;
            acc_d     = {32'd0, (is_signed ? abs_b : src_b)};
            res_neg_d = is_signed & (src_a[31] ^ src_b[31]);
            dvd_neg_d = 1'b0;
            state_d   = S_CALC;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MULDIV_DIV_EN
        if (op_q[1]) begin
          if (!div_diff[33]) acc_d = {div_diff[31:0], acc_q[30:0], 1'b1};
          else               acc_d = {acc_q[62:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:1]};
        end
`else
        if (acc_q[0]) acc_d = {mul_sum, acc_q[31:1]};
        else          acc_d = {1'b0, acc_q[63:1]};
`endif
        if (cnt_q == 6'd31) state_d = S_FIX;
      end

      S_FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (!op_q[1]) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
`ifdef MULDIV_DIV_EN
        else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      op_q      <= 2'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      res_neg_q <= 1'b0;
      dvd_neg_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      res_neg_q <= res_neg_d;
      dvd_neg_q <= dvd_neg_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the MIPS datapath. It consumes the two operand words read from the register file (rs on `src_a`, rt on `src_b`) and produces the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Radix-2, one bit per cycle, with a start/busy/done handshake so the controller can stall MFHI/MFLO until a result is ready.

## Interface
Parameters:
- none; data width is fixed at 32.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous and active-high.
- `start`  in  1  launch operation `op`; accepted only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `src_a`  in  32  rs operand (multiplicand/dividend); sampled with `start`.
- `src_b`  in  32  rt operand (multiplier/divisor); sampled with `start`.
- `hi_we`  in  1  MTHI; writes `wdata` to HI; honoured only in IDLE.
- `lo_we`  in  1  MTLO; writes `wdata` to LO; honoured only in IDLE.
- `wdata`  in  32  data for MTHI/MTLO.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE:
  - If `start`=1, latch operands, clear the 6-bit counter, go to CALC.
  - For signed ops (MULT, DIV), latch magnitudes plus a result-sign flag and a dividend-sign flag.
- CALC: 32 iterations, one per cycle; the counter increments each cycle; go to FIX after iteration 31.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 32-bit remainder plus quotient.
- FIX: apply sign correction, write HI/LO, assert `done`, return to IDLE.
  - Multiply: {HI,LO} = 64-bit product; negated if the result sign is negative.
  - Divide: LO = quotient, negated if the operand signs differ. HI = remainder, taking the sign of the dividend.
- Divide by zero (`src_b`=0, DIV or DIVU): full latency; LO=0xFFFFFFFF, HI=`src_a` unmodified, no sign fix.
- 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0; this is the natural result, with no special case.
- `start` while `busy`: ignored, with no effect on state.
- `hi_we`/`lo_we` while `busy`: ignored.
- `hi_we`/`lo_we` with `start` in the same IDLE cycle: the write takes effect, then the result overwrites HI/LO at FIX.
- `hi_we` and `lo_we` together: both registers are written.
- HI/LO are otherwise stable; they change only on MTHI/MTLO or at FIX.

## Timing
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0; state IDLE, counter 0.
- `rst` mid-operation aborts the operation: HI/LO are cleared to 0 and no `done` pulse is issued.
- `start` sampled at edge N:
  - `busy`=1 after edges N through N+32 (33 cycles: 32 CALC, 1 FIX).
  - HI/LO update and `done`=1 for exactly one cycle after edge N+33; `busy`=0 in that same cycle.
- Back-to-back: a new `start` is accepted in the `done` cycle (state is IDLE). The next result follows 34 edges later.
- MTHI/MTLO: HI/LO update at the sampling edge and are visible the next cycle.
- `busy` and `done` are registered; no combinational path from inputs to outputs.

## Configuration
- `MULDIV_DIV_EN`:
  - Defined: the divider datapath is compiled in and DIV/DIVU behave as above.
  - Undefined: the divider is removed. DIV/DIVU `start` goes directly to FIX, pulses `done` after edge N+1 with `busy` high for one cycle, and leaves HI/LO unchanged. Multiply behaviour and timing are unchanged.

## Test plan
- MULT 0xFFFFFFFF × 0x00000002 -> `done` after edge N+33; HI=0xFFFFFFFF, LO=0xFFFFFFFE. MULTU on the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 0x00000064 / 0 -> LO=0xFFFFFFFF, HI=0x00000064, same 34-edge latency. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start MULT 3×5, pulse `start` with DIV at cycle N+10 and `hi_we` with 0xAAAA at N+12 -> both ignored; HI=0, LO=15, single `done` pulse.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 in the same cycle -> both visible the next cycle; `busy` stays 0 and `done` stays 0.
- Assert `rst` at cycle N+20 of a MULTU -> `busy`=0, HI=LO=0, no `done`. A fresh MULTU 2×3 then gives LO=6, HI=0. With `MULDIV_DIV_EN` undefined, DIV gives `done` after N+1 and HI/LO are unchanged.
